// File: rtl/dtu_rd_cred_gate.sv
// dtu_rd_cred_gate: admits one read descriptor at a time and forwards it only
// when enough read-data beat credits are free. Credits are consumed by the
// issued descriptor's beat count and returned one per beat observed on the
// passive read-data tap.
module dtu_rd_cred_gate #(
    parameter int BEAT_BYTES = 64,
    parameter int MAX_BEATS  = 512,
    parameter int LEN_BITS   = 28,
    parameter int PID_BITS   = 6
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         s_req_valid,
    output logic                         s_req_ready,
    input  logic [LEN_BITS-1:0]          s_req_len,
    input  logic [PID_BITS-1:0]          s_req_pid,
    output logic                         m_req_valid,
    input  logic                         m_req_ready,
    output logic [LEN_BITS-1:0]          m_req_len,
    output logic [PID_BITS-1:0]          m_req_pid,
    input  logic                         mon_tvalid,
    input  logic                         mon_tready,
    output logic [$clog2(MAX_BEATS):0]   cred_free,
    output logic                         err_oversize,
    output logic                         err_overflow
);

    localparam int SH = $clog2(BEAT_BYTES);
    localparam int BW = LEN_BITS - SH + 1;
    localparam int CW = $clog2(MAX_BEATS) + 1;

    typedef enum logic [1:0] {IDLE, CALC, WAIT, ISSUE} state_t;

    state_t                state_q, state_d;
    logic                  s_req_ready_q, s_req_ready_d;
    logic                  m_req_valid_q, m_req_valid_d;
    logic [LEN_BITS-1:0]   len_q, len_d;
    logic [PID_BITS-1:0]   pid_q, pid_d;
    logic [BW-1:0]         beats_q, beats_d;
    logic [CW-1:0]         cred_free_q, cred_free_d;
    logic                  err_oversize_q, err_oversize_d;
    logic                  err_overflow_q, err_overflow_d;

    logic [BW-1:0]         beats_in;
    logic                  cred_ok;
    logic                  mon_beat;
    logic                  issue_hs;
    logic [CW:0]           cred_sum;

    // Beat count of the incoming descriptor: whole beats plus one for any partial tail.
    always_comb begin
        beats_in = BW'(s_req_len >> SH)
                 + BW'(|(s_req_len & LEN_BITS'(BEAT_BYTES - 1)));
    end

    // Handshake qualifiers and the credit sufficiency test for the held descriptor.
    always_comb begin
        mon_beat = mon_tvalid && mon_tready;
        issue_hs = m_req_valid_q && m_req_ready;
        cred_ok  = BW'(cred_free_q) >= beats_q;
    end

    // Credit pool: subtract on issue, add one per observed beat, saturate at the pool size.
    always_comb begin
        // NOTE: one extra bit of headroom lets the +1 overshoot be detected before saturating.
        cred_sum = {1'b0, cred_free_q}
                 - (issue_hs ? {1'b0, beats_q[CW-1:0]} : '0)
                 + {{CW{1'b0}}, mon_beat};
        err_overflow_d = err_overflow_q;
        if (cred_sum > (CW+1)'(MAX_BEATS)) begin
            cred_free_d    = CW'(MAX_BEATS);
            err_overflow_d = 1'b1;
        end else begin
            cred_free_d    = cred_sum[CW-1:0];
        end
    end

    // Descriptor FSM: next state and next values of its registered outputs.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d        = state_q;
        s_req_ready_d  = 1'b0;
        m_req_valid_d  = 1'b0;
        len_d          = len_q;
        pid_d          = pid_q;
        beats_d        = beats_q;
        err_oversize_d = err_oversize_q;
        case (state_q)
            IDLE: begin
                if (s_req_valid && s_req_ready_q) begin
                    len_d   = s_req_len;
                    pid_d   = s_req_pid;
                    beats_d = beats_in;
                    state_d = CALC;
                end else begin
                    s_req_ready_d = 1'b1;
                end
            end
            CALC: begin
                if (len_q == '0) begin
                    state_d       = IDLE;
                    s_req_ready_d = 1'b1;
                end else if (beats_q > BW'(MAX_BEATS)) begin
                    err_oversize_d = 1'b1;
                    state_d        = IDLE;
                    s_req_ready_d  = 1'b1;
                end else if (cred_ok) begin
                    state_d       = ISSUE;
                    m_req_valid_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cred_ok) begin
                    state_d       = ISSUE;
                    m_req_valid_d = 1'b1;
                end
            end
            ISSUE: begin
                if (m_req_ready) begin
                    state_d       = IDLE;
                    s_req_ready_d = 1'b1;
                end else begin
                    m_req_valid_d = 1'b1;
                end
            end
            default: begin
                state_d       = IDLE;
                s_req_ready_d = 1'b1;
            end
        endcase
    end

    // State, descriptor, credit and error registers with synchronous reset.
    always_ff @(posedge aclk) begin
        // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
        if (areset) begin
            state_q        <= IDLE;
            s_req_ready_q  <= 1'b0;
            m_req_valid_q  <= 1'b0;
            len_q          <= '0;
            pid_q          <= '0;
            beats_q        <= '0;
            cred_free_q    <= CW'(MAX_BEATS);
            err_oversize_q <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            s_req_ready_q  <= s_req_ready_d;
            m_req_valid_q  <= m_req_valid_d;
            len_q          <= len_d;
            pid_q          <= pid_d;
            beats_q        <= beats_d;
            cred_free_q    <= cred_free_d;
            err_oversize_q <= err_oversize_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign s_req_ready  = s_req_ready_q;
    assign m_req_valid  = m_req_valid_q;
    assign m_req_len    = len_q;
    assign m_req_pid    = pid_q;
    assign cred_free    = cred_free_q;
    assign err_oversize = err_oversize_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_dtu_rd_cred_gate.sv
// tb_dtu_rd_cred_gate: directed scenarios with literal expectations, plus a
// transaction-level reference model compared against the DUT every cycle.
module tb_dtu_rd_cred_gate;

    localparam int BEAT_BYTES = 64;
    localparam int MAX_BEATS  = 512;
    localparam int LEN_BITS   = 28;
    localparam int PID_BITS   = 6;
    localparam int CW         = $clog2(MAX_BEATS) + 1;

    logic                aclk = 1'b0;
    logic                areset;
    logic                s_req_valid;
    logic                s_req_ready;
    logic [LEN_BITS-1:0] s_req_len;
    logic [PID_BITS-1:0] s_req_pid;
    logic                m_req_valid;
    logic                m_req_ready;
    logic [LEN_BITS-1:0] m_req_len;
    logic [PID_BITS-1:0] m_req_pid;
    logic                mon_tvalid;
    logic                mon_tready;
    logic [CW-1:0]       cred_free;
    logic                err_oversize;
    logic                err_overflow;

    int n_checks = 0;
    int n_errors = 0;

    dtu_rd_cred_gate #(
        .BEAT_BYTES(BEAT_BYTES),
        .MAX_BEATS (MAX_BEATS),
        .LEN_BITS  (LEN_BITS),
        .PID_BITS  (PID_BITS)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_len   (s_req_len),
        .s_req_pid   (s_req_pid),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_len   (m_req_len),
        .m_req_pid   (m_req_pid),
        .mon_tvalid  (mon_tvalid),
        .mon_tready  (mon_tready),
        .cred_free   (cred_free),
        .err_oversize(err_oversize),
        .err_overflow(err_overflow)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected outputs for the current cycle, plus the one descriptor in flight.
    bit  model_on = 1'b0;
    bit  e_ready, e_valid, e_eos, e_eof;
    int  e_cred;
    bit  have, evaluated;
    int  p_len, p_pid, p_beats;

    always @(negedge aclk) begin
        bit hs_in, hs_out, mon, n_ready, n_valid;
        int c;
        if (model_on) begin
            check("m_s_req_ready", s_req_ready, e_ready);
            check("m_m_req_valid", m_req_valid, e_valid);
            check("m_cred_free", cred_free, e_cred);
            check("m_err_oversize", err_oversize, e_eos);
            check("m_err_overflow", err_overflow, e_eof);
            if (e_valid) begin
                check("m_m_req_len", m_req_len, p_len);
                check("m_m_req_pid", m_req_pid, p_pid);
            end
        end
        if (areset) begin
            model_on = 1'b1;
            e_ready = 0; e_valid = 0; e_eos = 0; e_eof = 0;
            e_cred = MAX_BEATS; have = 0; evaluated = 0;
        end else if (model_on) begin
            hs_in   = e_ready && s_req_valid;
            hs_out  = e_valid && m_req_ready;
            mon     = mon_tvalid && mon_tready;
            n_ready = e_ready;
            n_valid = e_valid;
            c = e_cred - (hs_out ? p_beats : 0) + (mon ? 1 : 0);
            if (c > MAX_BEATS) begin
                c = MAX_BEATS;
                e_eof = 1;
            end
            if (hs_in) begin
                have = 1; evaluated = 0;
                p_len = int'(s_req_len); p_pid = int'(s_req_pid);
                p_beats = (p_len + BEAT_BYTES - 1) / BEAT_BYTES;
                n_ready = 0;
            end else if (!have) begin
                n_ready = 1;
            end else if (!evaluated) begin
                if (p_len == 0) begin
                    have = 0; n_ready = 1;
                end else if (p_beats > MAX_BEATS) begin
                    have = 0; n_ready = 1; e_eos = 1;
                end else begin
                    evaluated = 1;
                    if (e_cred >= p_beats) n_valid = 1;
                end
            end else if (!e_valid) begin
                if (e_cred >= p_beats) n_valid = 1;
            end else if (hs_out) begin
                have = 0; n_valid = 0; n_ready = 1;
            end
            e_ready = n_ready;
            e_valid = n_valid;
            e_cred  = c;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input int len, input int pid);
        int n = 0;
        s_req_len   = LEN_BITS'(len);
        s_req_pid   = PID_BITS'(pid);
        s_req_valid = 1'b1;
        while (!s_req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!s_req_ready) check("send_timeout", 0, 1);
        tick();
        s_req_valid = 1'b0;
    endtask

    task automatic wait_issue();
        int n = 0;
        while (!(m_req_valid && m_req_ready) && n < 1000) begin
            tick();
            n++;
        end
        if (!(m_req_valid && m_req_ready)) check("issue_timeout", 0, 1);
        tick();
    endtask

    task automatic mon_beats(input int n);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        repeat (n) tick();
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        areset = 1'b1; s_req_valid = 1'b0; s_req_len = '0; s_req_pid = '0;
        m_req_ready = 1'b1; mon_tvalid = 1'b0; mon_tready = 1'b0;
        tick();
        tick();
        check("rst_ready", s_req_ready, 0);
        check("rst_valid", m_req_valid, 0);
        check("rst_cred", cred_free, 512);
        check("rst_flags", {err_oversize, err_overflow}, 0);
        areset = 1'b0;
        tick();
        check("post_rst_ready", s_req_ready, 1);

        // Basic issue: valid two cycles after accept, 4 beats consumed.
        send(256, 3);
        check("basic_valid_n1", m_req_valid, 0);
        tick();
        check("basic_valid_n2", m_req_valid, 1);
        check("basic_len", m_req_len, 256);
        check("basic_pid", m_req_pid, 3);
        tick();
        check("basic_cred", cred_free, 508);
        check("basic_ready_after", s_req_ready, 1);

        // Tap with tready low is not a beat; then return the 4 credits.
        mon_tvalid = 1'b1;
        repeat (3) tick();
        mon_tvalid = 1'b0;
        check("tap_no_beat", cred_free, 508);
        mon_beats(4);
        check("cred_refill", cred_free, 512);

        // Round-up: 65 bytes is 2 beats.
        send(65, 4);
        wait_issue();
        check("roundup_cred", cred_free, 510);
        mon_beats(2);
        check("roundup_return", cred_free, 512);

        // Credit exhaustion: exactly MAX_BEATS is accepted, then a 1-beat request waits.
        send(32768, 1);
        wait_issue();
        check("exhaust_cred", cred_free, 0);
        send(64, 5);
        tick();
        repeat (4) begin
            check("wait_valid", m_req_valid, 0);
            check("wait_ready", s_req_ready, 0);
            tick();
        end
        mon_beats(1);
        check("wait_cred1", cred_free, 1);
        check("wait_still_low", m_req_valid, 0);
        tick();
        check("wait_release_valid", m_req_valid, 1);
        check("wait_release_len", m_req_len, 64);
        tick();
        check("wait_cred0", cred_free, 0);

        // Backpressure, then handshake coinciding with a returning beat.
        mon_beats(512);
        check("full_cred", cred_free, 512);
        check("full_no_ovf", err_overflow, 0);
        m_req_ready = 1'b0;
        send(640, 9);
        tick();
        repeat (5) begin
            check("bp_valid", m_req_valid, 1);
            check("bp_len", m_req_len, 640);
            check("bp_pid", m_req_pid, 9);
            check("bp_ready", s_req_ready, 0);
            tick();
        end
        m_req_ready = 1'b1;
        mon_tvalid = 1'b1; mon_tready = 1'b1;
        tick();
        mon_tvalid = 1'b0; mon_tready = 1'b0;
        check("simul_cred", cred_free, 503);
        check("simul_valid", m_req_valid, 0);

        // Zero length is dropped silently.
        send(0, 2);
        tick();
        check("zero_ready", s_req_ready, 1);
        check("zero_flag", err_oversize, 0);
        repeat (2) begin
            check("zero_valid", m_req_valid, 0);
            tick();
        end
        check("zero_cred", cred_free, 503);

        // Oversize (625 beats) is dropped with a sticky flag.
        send(40000, 7);
        tick();
        check("oversize_flag", err_oversize, 1);
        check("oversize_valid", m_req_valid, 0);
        check("oversize_cred", cred_free, 503);

        // Overflow: a beat with the pool full saturates and flags.
        mon_beats(9);
        check("pre_ovf_cred", cred_free, 512);
        check("pre_ovf_flag", err_overflow, 0);
        mon_beats(1);
        check("ovf_flag", err_overflow, 1);
        check("ovf_cred", cred_free, 512);
        repeat (3) tick();
        check("sticky_flags", {err_oversize, err_overflow}, 2'b11);

        // Reset while a descriptor waits for credit.
        send(32768, 1);
        wait_issue();
        send(64, 5);
        tick();
        tick();
        check("prerst_wait_valid", m_req_valid, 0);
        areset = 1'b1;
        tick();
        check("midrst_valid", m_req_valid, 0);
        check("midrst_cred", cred_free, 512);
        check("midrst_flags", {err_oversize, err_overflow}, 0);
        check("midrst_ready", s_req_ready, 0);
        areset = 1'b0;
        tick();
        check("midrst_ready_after", s_req_ready, 1);
        repeat (3) begin
            check("midrst_no_issue", m_req_valid, 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dtu_rd_cred_gate.md
DTU_RD_CRED_GATE -- requirements
Module: dtu_rd_cred_gate

Interface
REQ-001 SHALL have parameters (name, default, meaning): BEAT_BYTES, 64, bytes per data beat (power of two); MAX_BEATS, 512, read-data beat credit pool; LEN_BITS, 28, request length width; PID_BITS, 6, request pid width.
REQ-002 SHALL have ports (name, direction, width, meaning): aclk, in, 1, clock.
REQ-003 areset, in, 1, reset (synchronous, active-high).
REQ-004 s_req_valid / s_req_ready, in / out, 1 / 1, upstream read descriptor handshake.
REQ-005 s_req_len / s_req_pid, in, LEN_BITS / PID_BITS, descriptor byte length / pid.
REQ-006 m_req_valid / m_req_ready, out / in, 1 / 1, descriptor handshake towards the bypass read queue.
REQ-007 m_req_len / m_req_pid, out, LEN_BITS / PID_BITS, forwarded descriptor fields.
REQ-008 mon_tvalid / mon_tready, in, 1 / 1, passive tap on the returning host read-data stream; one beat = both high.
REQ-009 cred_free, out, clog2(MAX_BEATS)+1, current free beat credits.
REQ-010 err_oversize / err_overflow, out, 1 / 1, sticky error flags.
REQ-011 Clocking and reset SHALL be exactly as decided: one clock (aclk); reset (areset) is synchronous and active-high.

Function
REQ-012 beats = ceil(len / BEAT_BYTES), computed with shift and round-up on the low bits, at LEN_BITS-log2(BEAT_BYTES)+1 width.
REQ-013 The FSM SHALL have states IDLE, CALC, WAIT, ISSUE.
REQ-014 IDLE: s_req_ready=1. On s_req handshake, register len, pid and beats, then go to CALC.
REQ-015 CALC: if len==0, drop the descriptor, consume no credit and go to IDLE.
REQ-016 CALC: if beats>MAX_BEATS, drop the descriptor, set err_oversize and go to IDLE.
REQ-017 CALC: else if cred_free>=beats, go to ISSUE; otherwise go to WAIT.
REQ-018 WAIT: go to ISSUE in the first cycle cred_free>=beats; stay in WAIT indefinitely otherwise.
REQ-019 ISSUE: m_req_valid=1 with m_req_len/m_req_pid equal to the registered values, held stable until m_req_ready. On handshake, go to IDLE.
REQ-020 s_req_ready SHALL be 0 in every state other than IDLE; m_req_valid SHALL be 0 in every state other than ISSUE.
REQ-021 Minimum latency SHALL be: s_req handshake at cycle N gives m_req_valid at cycle N+2; the next s_req_ready comes the cycle after the m_req handshake.
REQ-022 Credit update per cycle: cred_free_next = cred_free - (issue handshake ? beats : 0) + (mon beat ? 1 : 0).
REQ-023 Simultaneous issue and mon beat SHALL apply both terms in the same cycle.
REQ-024 If the result would exceed MAX_BEATS, cred_free SHALL saturate at MAX_BEATS and err_overflow SHALL be set.
REQ-025 cred_free SHALL never underflow; this is guaranteed by the ISSUE entry condition, since only issue subtracts.
REQ-026 The mon_* inputs are observe-only; the block SHALL drive no ready onto the data stream.
REQ-027 Error flags SHALL remain set until reset.

Reset
REQ-028 While areset is high at a rising aclk edge, the block SHALL reset to: state=IDLE, cred_free=MAX_BEATS, err_oversize=0, err_overflow=0, m_req_valid=0, registered len/pid/beats=0.
REQ-029 s_req_ready SHALL be 0 during the reset cycle and 1 in the first cycle after release.
REQ-030 Reset asserted in any state SHALL abandon any held descriptor without issuing it; credits return to MAX_BEATS.

Verification
REQ-031 Basic issue: reset release, then s_req len=256, pid=3 with m_req_ready=1 -> m_req_valid 2 cycles after the accept, m_req_len=256, m_req_pid=3, cred_free=508.
REQ-032 Round-up and credit return: len=65 -> 2 beats consumed; then 2 mon beats -> cred_free back to 512.
REQ-033 Credit exhaustion: issue len=32768 (512 beats), then len=64 -> FSM stays in WAIT with m_req_valid=0; one mon beat -> m_req_valid the following cycle, cred_free 1->0 on handshake.
REQ-034 Backpressure and simultaneous events: m_req_ready=0 for 5 cycles -> len/pid stable and s_req_ready=0 throughout; release together with a mon beat -> cred_free = old - beats + 1.
REQ-035 Errors: len=0 -> dropped, no m_req_valid, no flag; len=40000 (>512 beats) -> dropped, err_oversize=1; mon beat with cred_free=512 -> err_overflow=1, cred_free stays 512.
REQ-036 Reset mid-WAIT: areset for 1 cycle while in WAIT -> no m_req_valid, cred_free=512, both flags 0, s_req_ready=1 the next cycle.
